multicycle_carry_adder: RTL and testbench

Parametrised multi-cycle ripple-carry adder/subtractor. It computes a WIDTH-bit sum or difference CHUNK bits per clock, least-significant chunk first. A registered carry links the chunks, so wide operands can be added without a full-width combinational carry chain. It is the successor to the team's fixed 4-bit ripple-carry adder and adds subtract mode, a signed-overflow flag and a start/busy/done handshake. It sits as a shared arithmetic unit behind a simple controller.

---
 rtl/multicycle_carry_adder.sv | 132 +++++++++++++
 tb/tb_multicycle_carry_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_carry_adder.sv
// multicycle_carry_adder: WIDTH-bit adder/subtractor that walks the operands
// CHUNK bits per clock, least-significant chunk first, linking chunks through
// a registered carry. Operands are latched on start, so the inputs are free
// to change while the operation runs.
module multicycle_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] opa_r, opa_next_s;
  logic [WIDTH-1:0] opb_r, opb_next_s;
  logic [WIDTH-1:0] s_next_s;
  logic             carry_r, carry_next_s;
  logic [IW-1:0]    idx_r, idx_next_s;
  logic             c_next_s, v_next_s, busy_next_s, done_next_s;

  logic [CHUNK-1:0] a_chunk_s, b_chunk_s, sum_s;
  logic [CHUNK:0]   chunk_total_s;
  logic             cnext_s, cin_msb_s;

  // Chunk datapath: add the selected operand slices plus the running carry.
  always_comb begin
    a_chunk_s     = opa_r[int'(idx_r)*CHUNK +: CHUNK];
    b_chunk_s     = opb_r[int'(idx_r)*CHUNK +: CHUNK];
    chunk_total_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    sum_s         = chunk_total_s[CHUNK-1:0];
    cnext_s       = chunk_total_s[CHUNK];
    // The MSB sum bit is a^b^cin, so the carry into the MSB can be recovered
    // from it; only meaningful when the last chunk is selected.
    cin_msb_s     = sum_s[CHUNK-1] ^ a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1];
  end

  // FSM next-state and next register values; everything holds by default.
  always_comb begin
    state_next_s = state_r;
    opa_next_s   = opa_r;
    opb_next_s   = opb_r;
    carry_next_s = carry_r;
    idx_next_s   = idx_r;
    s_next_s     = S;
    c_next_s     = C;
    v_next_s     = V;
    busy_next_s  = busy;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          opa_next_s   = A;
          opb_next_s   = sub ? ~B : B;
          carry_next_s = sub;
          idx_next_s   = {IW{1'b0}};
          s_next_s     = {WIDTH{1'b0}};
          c_next_s     = 1'b0;
          v_next_s     = 1'b0;
          busy_next_s  = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        s_next_s[int'(idx_r)*CHUNK +: CHUNK] = sum_s;
        carry_next_s = cnext_s;
        if (idx_r == LAST_IDX) begin
          c_next_s     = cnext_s;
          v_next_s     = cin_msb_s ^ cnext_s;
          busy_next_s  = 1'b0;
          done_next_s  = 1'b1;
          idx_next_s   = {IW{1'b0}};
          state_next_s = IDLE;
        end else begin
          idx_next_s   = idx_r + IW'(1);
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      S       <= {WIDTH{1'b0}};
      C       <= 1'b0;
      V       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      opa_r   <= opa_next_s;
      opb_r   <= opb_next_s;
      carry_r <= carry_next_s;
      idx_r   <= idx_next_s;
      S       <= s_next_s;
      C       <= c_next_s;
      V       <= v_next_s;
      busy    <= busy_next_s;
      done    <= done_next_s;
    end
  end

endmodule

// File: tb/tb_multicycle_carry_adder.sv
// Bench for multicycle_carry_adder: directed and random operations on a
// 16/4 instance checked against a plain-arithmetic model, plus a 4/4 instance
// for the single-chunk configuration.
module tb_multicycle_carry_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub;
  logic [15:0] A, B, S;
  logic        C, V, busy, done;

  logic        d_start, d_sub;
  logic [3:0]  d_A, d_B, d_S;
  logic        d_C, d_V, d_busy, d_done;

  int total = 0;
  int bad   = 0;

  multicycle_carry_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .S(S), .C(C), .V(V), .busy(busy), .done(done)
  );

  multicycle_carry_adder #(.WIDTH(4), .CHUNK(4)) dut_one (
    .clk(clk), .rst(rst), .start(d_start), .sub(d_sub), .A(d_A), .B(d_B),
    .S(d_S), .C(d_C), .V(d_V), .busy(d_busy), .done(d_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {V, C, S} of A + (sub ? ~B : B) + sub using plain arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
    logic [15:0] bb;
    logic [16:0] full;
    logic        v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    v    = (a[15] == bb[15]) && (full[15] != a[15]);
    return {v, full[16], full[15:0]};
  endfunction

  // One full operation; optional disturbance pulses start and scrambles inputs during RUN.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input bit disturb);
    logic [17:0] exp;
    int lat;
    int busy_cnt;
    exp = ref_model(a, b, s);
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done", done, 0);
    check("accept_clear_S", S, 0);
    lat = 0;
    busy_cnt = 1;
    while (!done && lat < 10) begin
      if (disturb) begin
        start = 1'b1; A = ~a; B = a ^ b ^ 16'h5A5A; sub = ~s;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check("latency", lat, 4);
    check("busy_cycles", busy_cnt, 4);
    check("result_S", S, exp[15:0]);
    check("result_C", C, exp[16]);
    check("result_V", V, exp[17]);
    @(posedge clk); #1;
    check("done_pulse_end", done, 0);
    @(posedge clk); #1;
    check("hold_S", S, exp[15:0]);
    check("hold_C", C, exp[16]);
    check("hold_V", V, exp[17]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] exp1, exp2;
    int lat;
    int done_seen;

    rst = 1'b1; start = 1'b0; sub = 1'b0; A = 16'h0; B = 16'h0;
    d_start = 1'b0; d_sub = 1'b0; d_A = 4'h0; d_B = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_S", S, 0);
    check("rst_C", C, 0);
    check("rst_V", V, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle, no clock edge
    #3 rst = 1'b1;
    #1;
    check("async_rst_S", S, 0);
    check("async_rst_C", C, 0);
    check("async_rst_V", V, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Start and operands changing during RUN are ignored
    run_op(16'h1234, 16'h0F0F, 1'b0, 1'b1);
    run_op(16'h8001, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back: start held high through the done cycle
    exp1 = ref_model(16'h1111, 16'h2222, 1'b0);
    exp2 = ref_model(16'hABCD, 16'h1234, 1'b1);
    A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_lat", lat, 4);
    check("b2b_first_S", S, exp1[15:0]);
    A = 16'hABCD; B = 16'h1234; sub = 1'b1;
    @(posedge clk); #1;
    check("b2b_accept_busy", busy, 1);
    check("b2b_done_fell", done, 0);
    check("b2b_S_cleared", S, 0);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_done_spacing", lat, 5);
    check("b2b_second_S", S, exp2[15:0]);
    check("b2b_second_C", C, exp2[16]);
    check("b2b_second_V", V, exp2[17]);
    @(posedge clk); #1;

    // Abort: reset during the second RUN cycle
    A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_S", S, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_C", C, 0);
    #1 rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_idle_busy", busy, 0);

    // Random operations, some disturbed
    for (int i = 0; i < 25; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    // Single-chunk configuration
    d_A = 4'hF; d_B = 4'hF; d_sub = 1'b0; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    check("one_accept_busy", d_busy, 1);
    check("one_accept_done", d_done, 0);
    @(posedge clk); #1;
    check("one_done", d_done, 1);
    check("one_S", d_S, 14);
    check("one_C", d_C, 1);
    check("one_V", d_V, 0);
    check("one_busy_low", d_busy, 0);
    @(posedge clk); #1;
    check("one_done_end", d_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
